// File: rtl/apu_triangle_control.sv
// APU triangle channel control: registers, period timer, linear and length counters.
// Optional TRI_ULTRASONIC_MUTE_EN suppresses steps while period < 2.
module apu_triangle_control #(
  parameter int TIMER_W = 11,
  parameter int LIN_W   = 7
) (
  input  logic             cpu_clk,
  input  logic             reset,
  input  logic             reg_wr,
  input  logic [1:0]       reg_addr,
  input  logic [7:0]       reg_data,
  input  logic             enable,
  input  logic             quarter_frame,
  input  logic             half_frame,
  output logic             seq_clk,
  output logic             seq_step,
  output logic             length_active,
  output logic [LIN_W-1:0] linear_count
);

  function automatic logic [7:0] len_lookup(input logic [4:0] idx);
    case (idx)
      5'd0:  len_lookup = 8'd10;
      5'd1:  len_lookup = 8'd254;
      5'd2:  len_lookup = 8'd20;
      5'd3:  len_lookup = 8'd2;
      5'd4:  len_lookup = 8'd40;
      5'd5:  len_lookup = 8'd4;
      5'd6:  len_lookup = 8'd80;
      5'd7:  len_lookup = 8'd6;
      5'd8:  len_lookup = 8'd160;
      5'd9:  len_lookup = 8'd8;
      5'd10: len_lookup = 8'd60;
      5'd11: len_lookup = 8'd10;
      5'd12: len_lookup = 8'd14;
      5'd13: len_lookup = 8'd12;
      5'd14: len_lookup = 8'd26;
      5'd15: len_lookup = 8'd14;
      5'd16: len_lookup = 8'd12;
      5'd17: len_lookup = 8'd16;
      5'd18: len_lookup = 8'd24;
      5'd19: len_lookup = 8'd18;
      5'd20: len_lookup = 8'd48;
      5'd21: len_lookup = 8'd20;
      5'd22: len_lookup = 8'd96;
      5'd23: len_lookup = 8'd22;
      5'd24: len_lookup = 8'd192;
      5'd25: len_lookup = 8'd24;
      5'd26: len_lookup = 8'd72;
      5'd27: len_lookup = 8'd26;
      5'd28: len_lookup = 8'd16;
      5'd29: len_lookup = 8'd28;
      5'd30: len_lookup = 8'd32;
      default: len_lookup = 8'd30;
    endcase
  endfunction

  logic [TIMER_W-1:0] timer;
  logic [TIMER_W-1:0] period;
  logic [7:0]         length;
  logic [LIN_W-1:0]   linear;
  logic [LIN_W-1:0]   lin_reload_val;
  logic               ctrl;
  logic               reload_flag;
  logic               step_pending;

  logic wr_lin;
  logic wr_lo;
  logic wr_hi;
  logic zero_next;
  logic mute;
  logic gate_open;

  always_comb begin
    wr_lin    = reg_wr && (reg_addr == 2'd0);
    wr_lo     = reg_wr && (reg_addr == 2'd2);
    wr_hi     = reg_wr && (reg_addr == 2'd3);
    zero_next = (timer == '0) ? (period == '0)
                              : (timer == TIMER_W'(1));
`ifdef TRI_ULTRASONIC_MUTE_EN
    mute      = period < TIMER_W'(2);
`else
    mute      = 1'b0;
`endif
    gate_open = (linear != '0) && (length != 8'd0) && !mute;
  end

  // Gate is sampled on the edge the timer hits 0; the step lands one edge later.
  always_ff @(posedge cpu_clk or posedge reset) begin
    if (reset) begin
      timer        <= '0;
      step_pending <= 1'b0;
      seq_step     <= 1'b0;
      seq_clk      <= 1'b0;
    end else begin
      timer        <= (timer == '0) ? period : timer - TIMER_W'(1);
      step_pending <= zero_next && gate_open;
      seq_step     <= step_pending;
      if (step_pending)
        seq_clk <= ~seq_clk;
    end
  end

  always_ff @(posedge cpu_clk or posedge reset) begin
    if (reset) begin
      ctrl           <= 1'b0;
      lin_reload_val <= '0;
      period         <= '0;
    end else begin
      if (wr_lin) begin
        ctrl           <= reg_data[7];
        lin_reload_val <= LIN_W'(reg_data[6:0]);
      end
      if (wr_lo)
        period <= TIMER_W'({period[10:8], reg_data});
      if (wr_hi)
        period <= TIMER_W'({reg_data[2:0], period[7:0]});
    end
  end

  // A $400B set beats a same-cycle quarter-frame clear.
  always_ff @(posedge cpu_clk or posedge reset) begin
    if (reset) begin
      linear      <= '0;
      reload_flag <= 1'b0;
    end else begin
      if (quarter_frame) begin
        if (reload_flag)
          linear <= lin_reload_val;
        else if (linear != '0)
          linear <= linear - LIN_W'(1);
      end
      if (wr_hi)
        reload_flag <= 1'b1;
      else if (quarter_frame && !ctrl)
        reload_flag <= 1'b0;
    end
  end

  always_ff @(posedge cpu_clk or posedge reset) begin
    if (reset) begin
      length <= 8'd0;
    end else if (!enable) begin
      length <= 8'd0;
    end else if (wr_hi) begin
      length <= len_lookup(reg_data[7:3]);
    end else if (half_frame && !ctrl && length != 8'd0) begin
      length <= length - 8'd1;
    end
  end

  assign length_active = (length != 8'd0);
  assign linear_count  = linear;

endmodule

// File: tb/tb_apu_triangle_control.sv
// Scoreboard bench for apu_triangle_control: expected steps queued, monitor compares.
module tb_apu_triangle_control;

  logic       cpu_clk;
  logic       reset;
  logic       reg_wr;
  logic [1:0] reg_addr;
  logic [7:0] reg_data;
  logic       enable;
  logic       quarter_frame;
  logic       half_frame;
  logic       seq_clk;
  logic       seq_step;
  logic       length_active;
  logic [6:0] linear_count;

  apu_triangle_control dut (
    .cpu_clk      (cpu_clk),
    .reset        (reset),
    .reg_wr       (reg_wr),
    .reg_addr     (reg_addr),
    .reg_data     (reg_data),
    .enable       (enable),
    .quarter_frame(quarter_frame),
    .half_frame   (half_frame),
    .seq_clk      (seq_clk),
    .seq_step     (seq_step),
    .length_active(length_active),
    .linear_count (linear_count)
  );

  typedef struct {
    int   gap;
    logic lvl;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_step = 0;
  logic exp_lvl = 1'b0;

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  always @(posedge cpu_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // gap 0 means the phase of the first step is not pinned down
  task automatic push(input int gap);
    exp_t e;
    exp_lvl = ~exp_lvl;
    e.gap = gap;
    e.lvl = exp_lvl;
    sb.push_back(e);
  endtask

  always @(negedge cpu_clk) begin
    exp_t e;
    if (!reset && seq_step) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_step cycle=%0d actual=1 expected=0", cyc);
      end else begin
        e = sb.pop_front();
        if (e.gap != 0)
          chk("step_gap", cyc - last_step, e.gap);
        chk("seq_clk_level", {31'd0, seq_clk}, {31'd0, e.lvl});
      end
      last_step = cyc;
    end
  end

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    reg_wr   = 1'b1;
    reg_addr = a;
    reg_data = d;
    tick();
    reg_wr   = 1'b0;
  endtask

  task automatic qf();
    quarter_frame = 1'b1;
    tick();
    quarter_frame = 1'b0;
  endtask

  task automatic hf();
    half_frame = 1'b1;
    tick();
    half_frame = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int maxc);
    int n;
    n = 0;
    while (sb.size() != 0 && n < maxc) begin
      @(negedge cpu_clk);
      #1;
      n++;
    end
    chk(name, sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    reg_wr = 1'b0;
    reg_addr = 2'd0;
    reg_data = 8'd0;
    enable = 1'b0;
    quarter_frame = 1'b0;
    half_frame = 1'b0;
    repeat (3) tick();
    chk("rst_seq_clk", seq_clk, 0);
    chk("rst_seq_step", seq_step, 0);
    chk("rst_len_active", length_active, 0);
    chk("rst_linear", linear_count, 0);
    reset = 1'b0;
    enable = 1'b1;
    repeat (20) tick();
    chk("idle_seq_clk", seq_clk, 0);

    // step rate: period 5 -> toggle every 6 cycles
    wr(2'd0, 8'h81);
    wr(2'd2, 8'h05);
    wr(2'd3, 8'h08);
    chk("rate_len_active", length_active, 1);
    push(0);
    repeat (4) push(6);
    qf();
    chk("rate_linear", linear_count, 1);
    wait_drain("rate_drain", 100);

    // asynchronous reset while stepping
    reset = 1'b1;
    #1;
    chk("mid_rst_seq_clk", seq_clk, 0);
    chk("mid_rst_seq_step", seq_step, 0);
    chk("mid_rst_len_active", length_active, 0);
    chk("mid_rst_linear", linear_count, 0);
    exp_lvl = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    repeat (20) tick();
    chk("post_rst_seq_clk", seq_clk, 0);

    // linear expiry: 18 open cycles at period 5 -> 3 steps
    wr(2'd2, 8'h05);
    wr(2'd0, 8'h02);
    wr(2'd3, 8'h08);
    push(0);
    push(6);
    push(6);
    qf();
    chk("expiry_lin2", linear_count, 2);
    repeat (8) tick();
    qf();
    chk("expiry_lin1", linear_count, 1);
    repeat (8) tick();
    qf();
    chk("expiry_lin0", linear_count, 0);
    repeat (30) tick();
    wait_drain("expiry_drain", 1);
    chk("expiry_hold", seq_clk, exp_lvl);

    // length counter with and without halt
    wr(2'd3, 8'h18);
    chk("len2_active", length_active, 1);
    hf();
    chk("len1_active", length_active, 1);
    hf();
    chk("len0_active", length_active, 0);
    wr(2'd0, 8'h80);
    wr(2'd3, 8'h18);
    hf();
    hf();
    chk("halt_active", length_active, 1);
    wr(2'd0, 8'h00);
    hf();
    chk("halt_len1", length_active, 1);
    hf();
    chk("halt_len0", length_active, 0);

    // load beats same-cycle half_frame: 254 decrements needed
    reg_wr = 1'b1;
    reg_addr = 2'd3;
    reg_data = 8'h08;
    half_frame = 1'b1;
    tick();
    reg_wr = 1'b0;
    repeat (253) tick();
    half_frame = 1'b0;
    chk("collide_253", length_active, 1);
    hf();
    chk("collide_254", length_active, 0);

    // enable gating and period-1 stepping
    wr(2'd2, 8'h01);
    wr(2'd0, 8'h81);
    wr(2'd3, 8'h08);
    chk("en_load", length_active, 1);
    enable = 1'b0;
    tick();
    chk("enable_fall", length_active, 0);
    wr(2'd3, 8'h08);
    chk("load_ignored", length_active, 0);
    enable = 1'b1;
    wr(2'd3, 8'h08);
    chk("reload_on", length_active, 1);
`ifndef TRI_ULTRASONIC_MUTE_EN
    push(0);
    repeat (3) push(2);
`endif
    qf();
    chk("ultra_linear", linear_count, 1);
    wait_drain("ultra_drain", 100);
    enable = 1'b0;
`ifndef TRI_ULTRASONIC_MUTE_EN
    push(2);
`endif
    tick();
    chk("enable_stop", length_active, 0);
    repeat (20) tick();
    wait_drain("ultra_tail", 1);
    chk("ultra_hold", seq_clk, exp_lvl);

    repeat (10) tick();
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
